// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester round-robin front end for one shared shifter
// Optional stall counter output enabled by SHIFT_ARB_STALL_CNT_EN.

module shifter #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  output logic [WIDTH-1:0] result
);
  assign result = dir ? (data >> shamt) : (data << shamt);
endmodule

module shift_arbiter #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_data,
  input  logic [SHW-1:0]   i_req0_shamt,
  input  logic             i_req0_dir,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_data,
  input  logic [SHW-1:0]   i_req1_shamt,
  input  logic             i_req1_dir,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_id
`ifdef SHIFT_ARB_STALL_CNT_EN
  ,
  output logic [15:0]      o_stall_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic             any_valid;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic [SHW-1:0]   sel_shamt;
  logic             sel_dir;
  logic [WIDTH-1:0] shift_result;

  assign any_valid  = i_req0_valid | i_req1_valid;
  assign can_accept = (state == EMPTY) | i_rsp_ready;
  assign accept     = can_accept & any_valid & i_rst_n;

  // Under contention the requester not granted last time wins.
  always_comb begin
    grant = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      grant = ~last_grant;
    end else if (i_req1_valid) begin
      grant = 1'b1;
    end
  end

  assign o_req0_ready = accept & i_req0_valid & ~grant;
  assign o_req1_ready = accept & i_req1_valid & grant;

  assign sel_data  = grant ? i_req1_data  : i_req0_data;
  assign sel_shamt = grant ? i_req1_shamt : i_req0_shamt;
  assign sel_dir   = grant ? i_req1_dir   : i_req0_dir;

  shifter #(.WIDTH(WIDTH)) u_shifter (
    .data   (sel_data),
    .shamt  (sel_shamt),
    .dir    (sel_dir),
    .result (shift_result)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= EMPTY;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_id    <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state       <= FULL;
            o_rsp_valid <= 1'b1;
          end
        end
        FULL: begin
          if (!accept && i_rsp_ready) begin
            state       <= EMPTY;
            o_rsp_valid <= 1'b0;
          end
        end
        default: begin
          state       <= EMPTY;
          o_rsp_valid <= 1'b0;
        end
      endcase
      if (accept) begin
        o_rsp_data <= shift_result;
        o_rsp_id   <= grant;
        last_grant <= grant;
      end
    end
  end

`ifdef SHIFT_ARB_STALL_CNT_EN
  logic [1:0]  stall_inc;
  logic [16:0] stall_sum;

  always_comb begin
    stall_inc = 2'd0;
    if (any_valid && !accept) begin
      stall_inc = (i_req0_valid && i_req1_valid) ? 2'd2 : 2'd1;
    end
  end

  assign stall_sum = {1'b0, o_stall_cnt} + {15'd0, stall_inc};

  // Carry out of the 16-bit sum means the counter would wrap; pin it instead.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= 16'd0;
    end else begin
      o_stall_cnt <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed self-checking bench for shift_arbiter

`timescale 1ns/1ps

module tb_shift_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_req0_valid, i_req1_valid;
  logic       o_req0_ready, o_req1_ready;
  logic [7:0] i_req0_data, i_req1_data;
  logic [2:0] i_req0_shamt, i_req1_shamt;
  logic       i_req0_dir, i_req1_dir;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic [7:0] o_rsp_data;
  logic       o_rsp_id;
`ifdef SHIFT_ARB_STALL_CNT_EN
  logic [15:0] o_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  shift_arbiter #(.WIDTH(8)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req0_valid (i_req0_valid),
    .o_req0_ready (o_req0_ready),
    .i_req0_data  (i_req0_data),
    .i_req0_shamt (i_req0_shamt),
    .i_req0_dir   (i_req0_dir),
    .i_req1_valid (i_req1_valid),
    .o_req1_ready (o_req1_ready),
    .i_req1_data  (i_req1_data),
    .i_req1_shamt (i_req1_shamt),
    .i_req1_dir   (i_req1_dir),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_id     (o_rsp_id)
`ifdef SHIFT_ARB_STALL_CNT_EN
    ,
    .o_stall_cnt  (o_stall_cnt)
`endif
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst_n      = 1'b0;
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    i_rsp_ready  = 1'b1;
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n      = 1'b0;
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    i_req0_data  = 8'hFF; i_req0_shamt = 3'd1; i_req0_dir = 1'b0;
    i_req1_data  = 8'hFF; i_req1_shamt = 3'd1; i_req1_dir = 1'b1;
    i_rsp_ready  = 1'b1;
    step();
    step();
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_rsp_valid); end
    checks++; if (o_rsp_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", o_rsp_data); end
    checks++; if (o_rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id got %b exp 0", o_rsp_id); end
    checks++; if (o_req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %b exp 0", o_req0_ready); end
    checks++; if (o_req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %b exp 0", o_req1_ready); end
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    step();
    i_rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    i_req0_valid = 1'b1; i_req0_data = 8'hB5; i_req0_shamt = 3'd3; i_req0_dir = 1'b0;
    @(negedge i_clk);
    checks++; if (o_req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got %b exp 1", o_req0_ready); end
    checks++; if (o_req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1 got %b exp 0", o_req1_ready); end
    step();
    i_req0_valid = 1'b0;
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL single_left_valid got %b exp 1", o_rsp_valid); end
    checks++; if (o_rsp_data !== 8'hA8) begin errors++; $display("FAIL single_left_data got %h exp a8", o_rsp_data); end
    checks++; if (o_rsp_id !== 1'b0) begin errors++; $display("FAIL single_left_id got %b exp 0", o_rsp_id); end
    i_req0_valid = 1'b1; i_req0_dir = 1'b1;
    @(negedge i_clk);
    checks++; if (o_req0_ready !== 1'b1) begin errors++; $display("FAIL single_full_ready0 got %b exp 1", o_req0_ready); end
    step();
    i_req0_valid = 1'b0;
    @(negedge i_clk);
    checks++; if (o_rsp_data !== 8'h16) begin errors++; $display("FAIL single_right_data got %h exp 16", o_rsp_data); end
    checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL single_right_valid got %b exp 1", o_rsp_valid); end
    checks++; if (o_req0_ready !== 1'b0) begin errors++; $display("FAIL idle_ready0 got %b exp 0", o_req0_ready); end
    step();
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %b exp 0", o_rsp_valid); end
  endtask

  task automatic test_contention();
    logic [7:0] exp_data [4];
    logic       exp_id   [4];
    exp_data[0] = 8'hF0; exp_id[0] = 1'b0;
    exp_data[1] = 8'h01; exp_id[1] = 1'b1;
    exp_data[2] = 8'hF0; exp_id[2] = 1'b0;
    exp_data[3] = 8'h01; exp_id[3] = 1'b1;
    apply_reset();
    i_req0_valid = 1'b1; i_req0_data = 8'h0F; i_req0_shamt = 3'd4; i_req0_dir = 1'b0;
    i_req1_valid = 1'b1; i_req1_data = 8'h81; i_req1_shamt = 3'd7; i_req1_dir = 1'b1;
    i_rsp_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      if (i > 0) begin
        checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL cont_valid[%0d] got %b exp 1", i-1, o_rsp_valid); end
        checks++; if (o_rsp_data !== exp_data[i-1]) begin errors++; $display("FAIL cont_data[%0d] got %h exp %h", i-1, o_rsp_data, exp_data[i-1]); end
        checks++; if (o_rsp_id !== exp_id[i-1]) begin errors++; $display("FAIL cont_id[%0d] got %b exp %b", i-1, o_rsp_id, exp_id[i-1]); end
      end
      checks++; if (o_req0_ready !== ~exp_id[i]) begin errors++; $display("FAIL cont_ready0[%0d] got %b exp %b", i, o_req0_ready, ~exp_id[i]); end
      checks++; if (o_req1_ready !== exp_id[i]) begin errors++; $display("FAIL cont_ready1[%0d] got %b exp %b", i, o_req1_ready, exp_id[i]); end
      step();
    end
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    @(negedge i_clk);
    checks++; if (o_rsp_data !== exp_data[3]) begin errors++; $display("FAIL cont_data[3] got %h exp %h", o_rsp_data, exp_data[3]); end
    checks++; if (o_rsp_id !== exp_id[3]) begin errors++; $display("FAIL cont_id[3] got %b exp %b", o_rsp_id, exp_id[3]); end
    step();
  endtask

  task automatic test_backpressure();
    apply_reset();
    i_rsp_ready  = 1'b0;
    i_req0_valid = 1'b1; i_req0_data = 8'h0F; i_req0_shamt = 3'd4; i_req0_dir = 1'b0;
    step();
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b1; i_req1_data = 8'h81; i_req1_shamt = 3'd7; i_req1_dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, o_rsp_valid); end
      checks++; if (o_rsp_data !== 8'hF0) begin errors++; $display("FAIL bp_data[%0d] got %h exp f0", i, o_rsp_data); end
      checks++; if (o_rsp_id !== 1'b0) begin errors++; $display("FAIL bp_id[%0d] got %b exp 0", i, o_rsp_id); end
      checks++; if ({o_req0_ready, o_req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_readies[%0d] got %b%b exp 00", i, o_req0_ready, o_req1_ready); end
      step();
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    checks++; if (o_req1_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready1 got %b exp 1", o_req1_ready); end
    step();
    i_req1_valid = 1'b0;
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_b2b_valid got %b exp 1", o_rsp_valid); end
    checks++; if (o_rsp_data !== 8'h01) begin errors++; $display("FAIL bp_b2b_data got %h exp 01", o_rsp_data); end
    checks++; if (o_rsp_id !== 1'b1) begin errors++; $display("FAIL bp_b2b_id got %b exp 1", o_rsp_id); end
    step();
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got %b exp 0", o_rsp_valid); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    i_rsp_ready  = 1'b0;
    i_req1_valid = 1'b1; i_req1_data = 8'h81; i_req1_shamt = 3'd7; i_req1_dir = 1'b1;
    step();
    i_req1_valid = 1'b0;
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_full_valid got %b exp 1", o_rsp_valid); end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b exp 0", o_rsp_valid); end
    checks++; if (o_rsp_data !== 8'h00) begin errors++; $display("FAIL mid_async_data got %h exp 00", o_rsp_data); end
    checks++; if (o_rsp_id !== 1'b0) begin errors++; $display("FAIL mid_async_id got %b exp 0", o_rsp_id); end
    step();
    i_rst_n = 1'b1;
    i_rsp_ready  = 1'b1;
    i_req0_valid = 1'b1; i_req0_data = 8'h0F; i_req0_shamt = 3'd4; i_req0_dir = 1'b0;
    i_req1_valid = 1'b1;
    @(negedge i_clk);
    checks++; if (o_req0_ready !== 1'b1) begin errors++; $display("FAIL mid_first_ready0 got %b exp 1", o_req0_ready); end
    checks++; if (o_req1_ready !== 1'b0) begin errors++; $display("FAIL mid_first_ready1 got %b exp 0", o_req1_ready); end
    step();
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    @(negedge i_clk);
    checks++; if (o_rsp_id !== 1'b0) begin errors++; $display("FAIL mid_first_id got %b exp 0", o_rsp_id); end
    checks++; if (o_rsp_data !== 8'hF0) begin errors++; $display("FAIL mid_first_data got %h exp f0", o_rsp_data); end
    step();
  endtask

`ifdef SHIFT_ARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    apply_reset();
    i_rsp_ready  = 1'b0;
    i_req0_valid = 1'b1; i_req0_data = 8'h0F; i_req0_shamt = 3'd4; i_req0_dir = 1'b0;
    i_req1_valid = 1'b1; i_req1_data = 8'h81; i_req1_shamt = 3'd7; i_req1_dir = 1'b1;
    step();
    step();
    step();
    step();
    @(negedge i_clk);
    checks++; if (o_stall_cnt !== 16'd6) begin errors++; $display("FAIL stall_cnt got %0d exp 6", o_stall_cnt); end
    for (int i = 0; i < 32800; i++) step();
    @(negedge i_clk);
    checks++; if (o_stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat got %h exp ffff", o_stall_cnt); end
    step();
    @(negedge i_clk);
    checks++; if (o_stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_hold got %h exp ffff", o_stall_cnt); end
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    apply_reset();
    @(negedge i_clk);
    checks++; if (o_stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_reset got %0d exp 0", o_stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
`ifdef SHIFT_ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
